apb4_ram: RTL
=============

Name: apb4_ram

Overview:
Parametrised APB4 completer RAM. It is the next-generation replacement for the fixed-size APB RAM completer used in the APB verification environment.
- Adds configurable address, data and depth.
- Adds fixed programmable wait states and byte-strobe writes (pstrb).
- Adds pprot-based secure-region protection, and pslverr on illegal accesses.
- Sits behind one APB requester; one transfer in flight at a time.

Parameters:
ADDR_WIDTH, 12, paddr width in bits.
DATA_WIDTH, 32, pwdata/prdata width; legal values 8, 16, 32, 64.
DEPTH, 256, number of DATA_WIDTH words; DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
WAIT_STATES, 0, extra ACCESS cycles before pready; range 0..15.
SECURE_BASE, 256, first word index of the secure region; SECURE_BASE == DEPTH means no secure region.

Ports:
pclk  in  1  clock, rising-edge.
preset  in  1  synchronous active-high reset.
psel  in  1  completer select.
penable  in  1  access-phase indicator.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  write byte strobes.
pprot  in  3  protection; bit 1 = non-secure.
prdata  out  DATA_WIDTH  read data.
pready  out  1  transfer completion.
pslverr  out  1  transfer error; valid only with pready.

Behaviour:
- Interface: one clock pclk; reset preset is synchronous and active-high.
- Reset: pready=0, pslverr=0, prdata=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Reset mid-transfer aborts the transfer. No write commits in the reset cycle.
- FSM states:
  - IDLE: psel=1, penable=0 -> SETUP. penable=1 without a prior SETUP is ignored and stays IDLE.
  - SETUP: next cycle -> ACCESS. Address, control and data are captured at the end of SETUP.
  - ACCESS: the counter increments each cycle until it equals WAIT_STATES.
- Completion cycle (pready=1):
  - pready is high in ACCESS cycle number WAIT_STATES+1; outputs are registered.
  - With WAIT_STATES=0, pready is high in the first ACCESS cycle.
  - After completion: psel=1 and penable=0 -> SETUP (back-to-back transfer); psel=0 -> IDLE.
- Word index: idx = paddr >> log2(DATA_WIDTH/8).
- Error conditions (any one -> pslverr=1 in the completion cycle):
  - misaligned: the low log2(DATA_WIDTH/8) paddr bits are nonzero;
  - out of range: idx >= DEPTH;
  - secure violation: idx >= SECURE_BASE with pprot[1]=1.
- On error: no memory update; prdata=0.
- Write: at the completion edge, byte lane i is updated only where pstrb[i]=1. pstrb=0 is a legal no-op.
- Read: prdata = mem[idx] during the completion cycle only, 0 in all other cycles. pstrb is ignored on reads.
- Read after write to the same idx in the next transfer returns the new data (no stale bypass hazard).
- pslverr is 0 whenever pready is 0.
- If psel or penable drops mid-ACCESS (protocol violation): return to IDLE, no write, pready stays 0.
- Wait counter width is 4 bits; it clears on entry to SETUP.

Decomposition:
- apb_pkg additions:
  - apb_state_e enum {IDLE, SETUP, ACCESS};
  - localparam function for strobe width;
  - APB4 pprot bit-index constants (PPROT_PRIV=0, PPROT_NSEC=1, PPROT_INSTR=2).
- Sub-module apb4_ram_mem: DEPTH x DATA_WIDTH byte-lane-enabled synchronous array with a write port (we, strb, idx, wdata) and a read port. apb4_ram holds the FSM, wait counter, error decode and output registers.

Test Plan:
1. DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to paddr 0x010 with pstrb=4'hF, then read 0x010 -> prdata=0xDEADBEEF, pready high in the first ACCESS cycle, pslverr=0.
2. Over 0x11223344 at 0x020, write 0xAABBCCDD with pstrb=4'b0101, then read -> 0x11BB33DD.
3. WAIT_STATES=3: any read -> pready low for 3 ACCESS cycles and high on the 4th; prdata=0 before completion.
4. Errors, each -> pslverr=1 with pready, memory unchanged:
   - write to paddr 0x002 (misaligned);
   - write to idx 256 with DEPTH=256 (out of range);
   - SECURE_BASE=128, pprot=3'b010, write to idx 200 (secure violation).
   - A read of idx 200 with pprot=3'b000 then returns the prior value, pslverr=0.
5. Back-to-back transfers: write 0x5 to 0x000, read 0x000, write 0x6 to 0x004 without psel deasserting -> correct data and 0 errors, one SETUP per transfer.
6. WAIT_STATES=2, write 0xFFFFFFFF to 0x030, assert preset in the 2nd ACCESS cycle -> pready=0, FSM=IDLE next cycle; a subsequent read of 0x030 returns the pre-reset contents.

Source files
------------

// File: rtl/apb4_ram_pkg.sv
// Shared types and constants for the APB4 completer RAM.
package apb4_ram_pkg;

  typedef logic [1:0] apb_state_e;

  localparam apb_state_e IDLE   = 2'd0;
  localparam apb_state_e SETUP  = 2'd1;
  localparam apb_state_e ACCESS = 2'd2;

  localparam int unsigned PPROT_PRIV  = 0;
  localparam int unsigned PPROT_NSEC  = 1;
  localparam int unsigned PPROT_INSTR = 2;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb4_ram_if.sv
// APB4 bus bundle between one requester and one completer.
interface apb4_ram_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb4_ram_mem.sv
// Word array with per-byte-lane synchronous write and combinational read.
module apb4_ram_mem
  import apb4_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [strb_width(DATA_WIDTH)-1:0] strb,
  input  logic [IDX_W-1:0]                  widx,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [IDX_W-1:0]                  ridx,
  output logic [DATA_WIDTH-1:0]             rdata
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb4_ram.sv
// APB4 completer RAM: FSM, wait counter, error decode and registered outputs.
module apb4_ram
  import apb4_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned SECURE_BASE = 256
) (
  input logic       pclk,
  input logic       preset,
  apb4_ram_if.slave bus
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned LSB    = lane_bits(DATA_WIDTH);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  apb_state_e state_q, state_d, cur_state;
  logic [3:0] cnt_q, cnt_d;
  logic       in_access, load, complete;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q, nsec_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;

  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [ADDR_WIDTH-1:0] addr_m, idx, widx_full;
  logic                  write_m, nsec_m, err, mem_we;
  logic [31:0]           idx_ext;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_prot;

  assign unused_prot = bus.pprot[PPROT_PRIV] ^ bus.pprot[PPROT_INSTR];

  // SETUP is the unregistered sampling cycle, so pready can be a flop and still
  // rise in the first ACCESS cycle when there are no wait states.
  assign in_access = (state_q == ACCESS);
  assign cur_state = in_access ? ACCESS : (bus.psel && !bus.penable) ? SETUP : IDLE;

  // Decode from the live bus in SETUP, from the captured request afterwards.
  assign addr_m  = in_access ? addr_q  : bus.paddr;
  assign write_m = in_access ? write_q : bus.pwrite;
  assign nsec_m  = in_access ? nsec_q  : bus.pprot[PPROT_NSEC];
  assign idx     = addr_m >> LSB;
  assign idx_ext = 32'(idx);
  assign err     = ((addr_m & ADDR_WIDTH'(STRB_W - 1)) != '0) || (idx_ext >= DEPTH) ||
                   (nsec_m && (idx_ext >= SECURE_BASE));

  // Writes commit at the edge closing the completion cycle, never under reset.
  assign mem_we    = in_access && pready_q && bus.psel && bus.penable && write_q &&
                     !pslverr_q && !preset;
  assign widx_full = addr_q >> LSB;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    complete = 1'b0;
    unique case (cur_state)
      SETUP: begin
        state_d  = ACCESS;
        cnt_d    = '0;
        load     = 1'b1;
        complete = (WS == 4'd0);
      end
      ACCESS: begin
        if (!(bus.psel && bus.penable) || pready_q) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          complete = (cnt_d == WS);
        end
      end
      default: ;
    endcase
    pready_d  = complete;
    pslverr_d = complete && err;
    prdata_d  = (complete && !err && !write_m) ? rdata : '0;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (load && !preset) begin
      addr_q  <= bus.paddr;
      write_q <= bus.pwrite;
      nsec_q  <= bus.pprot[PPROT_NSEC];
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
    end
  end

  apb4_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .strb  (strb_q),
    .widx  (widx_full[IDX_W-1:0]),
    .wdata (wdata_q),
    .ridx  (idx[IDX_W-1:0]),
    .rdata (rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule
